// File: rtl/inst_prefetch_queue_pkg.sv
// Shared constants for the instruction prefetch queue and its consumers.
// Optional feature macro: IPQ_BYPASS_EN (see inst_prefetch_queue.sv).
package inst_prefetch_queue_pkg;

  localparam int          IPQ_XLEN     = 32;
  localparam logic [31:0] IPQ_RESET_PC = 32'h0000_0000;
  localparam int          INST_BYTES   = 4;
  // Fetch substitutes this when the queue has nothing valid to offer.
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;

  function automatic int ipq_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/inst_prefetch_queue_if.sv
// Memory request/response, redirect and fetch handshake bundle of the prefetch queue.
// master = prefetch queue side, slave = memory/execute/fetch environment.
interface inst_prefetch_queue_if
  import inst_prefetch_queue_pkg::*;
#(
  parameter int XLEN = IPQ_XLEN
);
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic [XLEN-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;
  logic            inst_ready;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/inst_prefetch_queue_fifo.sv
// ipq_fifo: DEPTH x W synchronous FIFO with clear; head reads as zero when empty.
// Storage is not reset, only pointers and count.
module ipq_fifo
  import inst_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [ipq_cnt_w(DEPTH)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop, empty;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push && ((count != FULL_CNT) || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: credit-limited sequential fetch, in-order buffering, redirect flush.
// Define IPQ_BYPASS_EN to forward a response straight to inst_* when the queue is empty.
module inst_prefetch_queue
  import inst_prefetch_queue_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              XLEN     = IPQ_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IPQ_RESET_PC)
) (
  input  logic                        clk,
  input  logic                        reset,
  inst_prefetch_queue_if.master       bus
);
  localparam int CW = ipq_cnt_w(DEPTH);

  logic [XLEN-1:0]   req_pc;
  logic [CW-1:0]     outstanding, drop_cnt, q_count, pcq_count;
  logic [CW:0]       credit_used;
  logic [XLEN-1:0]   pc_head, q_data, q_pc;
  logic              req_fire, rsp_accept, dropping, rsp_live, bypass_hit, q_empty;

  // Every issued request owns a queue slot until its word is consumed or dropped.
  assign credit_used        = {1'b0, q_count} + {1'b0, outstanding};
  assign bus.imem_req_valid = reset && !bus.redirect && (credit_used < (CW+1)'(DEPTH));
  assign bus.imem_req_addr  = req_pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign rsp_accept = bus.imem_rsp_valid && (outstanding != '0);
  assign dropping   = (drop_cnt != '0);
  assign rsp_live   = rsp_accept && !dropping && !bus.redirect;
  assign q_empty    = (q_count == '0);

`ifdef IPQ_BYPASS_EN
  assign bypass_hit = reset && q_empty && rsp_live;
`else
  assign bypass_hit = 1'b0;
`endif

  assign bus.inst_valid = !q_empty || bypass_hit;
  assign bus.inst_data  = bypass_hit ? bus.imem_rsp_data : q_data;
  assign bus.inst_pc    = bypass_hit ? pc_head : q_pc;

  // PCs of live (non-dropped) requests, in issue order.
  ipq_fifo #(.DEPTH(DEPTH), .W(XLEN)) u_pc_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (bus.redirect),
    .push      (req_fire),
    .push_data (req_pc),
    .pop       (rsp_accept && !dropping),
    .head      (pc_head),
    .count     (pcq_count)
  );

  ipq_fifo #(.DEPTH(DEPTH), .W(2*XLEN)) u_inst_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (bus.redirect),
    .push      (rsp_live && !(bypass_hit && bus.inst_ready)),
    .push_data ({bus.imem_rsp_data, pc_head}),
    .pop       (bus.inst_ready && !bus.redirect),
    .head      ({q_data, q_pc}),
    .count     (q_count)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      req_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + {{(CW-1){1'b0}}, req_fire} - {{(CW-1){1'b0}}, rsp_accept};
      if (bus.redirect) begin
        // Everything still in flight becomes stale, except a response landing now.
        req_pc   <= bus.redirect_pc;
        drop_cnt <= outstanding - {{(CW-1){1'b0}}, rsp_accept};
      end else begin
        if (req_fire) req_pc <= req_pc + XLEN'(INST_BYTES);
        drop_cnt <= drop_cnt - {{(CW-1){1'b0}}, (rsp_accept && dropping)};
      end
    end
  end

  a_rsp_has_owner: assert property (@(posedge clk) disable iff (!reset)
    bus.imem_rsp_valid |-> (outstanding != '0));
  a_inflight_split: assert property (@(posedge clk) disable iff (!reset)
    ({1'b0, pcq_count} + {1'b0, drop_cnt}) == {1'b0, outstanding});

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Randomized bench for inst_prefetch_queue against a queue-level reference model.
module tb_inst_prefetch_queue;
  import inst_prefetch_queue_pkg::*;

  typedef struct { logic [31:0] addr; int due; bit stale; } mreq_t;
  typedef struct { logic [31:0] data; logic [31:0] pc; } ent_t;

  logic clk;
  logic reset;
  inst_prefetch_queue_if bus_if ();

  inst_prefetch_queue dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;
  int last_due = 0;
  logic [31:0] m_req_pc;
  mreq_t mq[$];
  ent_t  iq[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s cyc=%0d: observed %h, expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus_if.imem_req_ready = 1'b0;
    bus_if.imem_rsp_valid = 1'b0;
    bus_if.imem_rsp_data  = '0;
    bus_if.redirect       = 1'b0;
    bus_if.redirect_pc    = '0;
    bus_if.inst_ready     = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
    chk("rst_req_valid", {31'b0, bus_if.imem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'b0, bus_if.inst_valid}, 32'd0);
    chk("rst_inst_data", bus_if.inst_data, 32'd0);
    chk("rst_inst_pc", bus_if.inst_pc, 32'd0);
    reset = 1'b1;
    mq.delete();
    iq.delete();
    m_req_pc = 32'h0;
    cyc++;
    last_due = cyc;
  endtask

  // One clock: drive inputs, compare against the model, then advance the model.
  task automatic step(input int rdy_p, input int ir_p, input int rd_p, input int lat,
                      input logic [31:0] rpc);
    bit rdy, ir, rd, rv, live, byp, exp_rv, exp_iv;
    logic [31:0] exp_d, exp_p, rsp_d;
    mreq_t h;
    ent_t  e;
    rdy = ($urandom_range(99) < rdy_p);
    ir  = ($urandom_range(99) < ir_p);
    rd  = ($urandom_range(99) < rd_p);
    rv  = (mq.size() > 0) && (mq[0].due <= cyc);
    rsp_d = rv ? mem_word(mq[0].addr) : $urandom;
    bus_if.imem_req_ready = rdy;
    bus_if.inst_ready     = ir;
    bus_if.redirect       = rd;
    bus_if.redirect_pc    = rpc;
    bus_if.imem_rsp_valid = rv;
    bus_if.imem_rsp_data  = rsp_d;
    #1;
    live   = rv && !mq[0].stale && !rd;
    exp_rv = !rd && ((iq.size() + mq.size()) < 4);
`ifdef IPQ_BYPASS_EN
    byp = (iq.size() == 0) && live;
`else
    byp = 1'b0;
`endif
    exp_iv = (iq.size() > 0) || byp;
    exp_d  = (iq.size() > 0) ? iq[0].data : (byp ? rsp_d : 32'd0);
    exp_p  = (iq.size() > 0) ? iq[0].pc : (byp ? mq[0].addr : 32'd0);
    chk("req_valid", {31'b0, bus_if.imem_req_valid}, {31'b0, exp_rv});
    chk("req_addr", bus_if.imem_req_addr, m_req_pc);
    chk("inst_valid", {31'b0, bus_if.inst_valid}, {31'b0, exp_iv});
    chk("inst_data", bus_if.inst_data, exp_d);
    chk("inst_pc", bus_if.inst_pc, exp_p);

    if (rv) h = mq.pop_front();
    if (rd) begin
      iq.delete();
      foreach (mq[i]) mq[i].stale = 1'b1;
      m_req_pc = rpc;
    end else begin
      if (iq.size() > 0 && ir) void'(iq.pop_front());
      if (live && !(byp && ir)) begin
        e.data = rsp_d;
        e.pc   = h.addr;
        iq.push_back(e);
      end
      if (exp_rv && rdy) begin
        h.addr  = m_req_pc;
        h.due   = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        h.stale = 1'b0;
        last_due = h.due;
        mq.push_back(h);
        m_req_pc = m_req_pc + 32'd4;
      end
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    m_req_pc = 32'h0;
    do_reset();

    // Latency 1, always ready: steady sequential stream.
    repeat (20) step(100, 100, 0, 1, 32'h0);
    // Fetch stalled: queue fills to DEPTH, requests stop; then one pop.
    repeat (12) step(100, 0, 0, 1, 32'h0);
    step(100, 100, 0, 1, 32'h0);
    repeat (4) step(100, 0, 0, 1, 32'h0);
    repeat (6) step(100, 100, 0, 1, 32'h0);
    // Latency 3 with requests in flight, then redirect to 0x100.
    repeat (6) step(100, 100, 0, 3, 32'h0);
    step(100, 100, 100, 3, 32'h100);
    repeat (15) step(100, 100, 0, 3, 32'h0);
    // Redirect coinciding with a response and a pop.
    repeat (6) step(100, 100, 0, 1, 32'h0);
    step(100, 100, 100, 1, 32'h200);
    repeat (8) step(100, 100, 0, 1, 32'h0);
    // Memory not ready for 5 cycles, then released.
    repeat (5) step(0, 100, 0, 1, 32'h0);
    repeat (10) step(100, 100, 0, 1, 32'h0);
    // Mixed random traffic, including back-to-back redirects.
    repeat (500) step(70, 60, 6, int'($urandom_range(3, 1)), $urandom & 32'hFFFF_FFFC);
    // Reset with requests in flight.
    repeat (2) step(100, 100, 0, 3, 32'h0);
    do_reset();
    repeat (12) step(100, 100, 0, 1, 32'h0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
